// File: rtl/tone_i2s_tx.sv
//------------------------------------------------------------------------------
// tone_i2s_tx
//
// Output stage of the synth voice datapath. Once per audio frame the mixed
// 32-bit signed TONE word is arithmetically scaled down by SHIFT bits. It is
// then saturated to 16 bits and held in a pending buffer. At the next frame
// start the pending sample moves into the play buffer. The play buffer is
// serialised MSB first, in I2S format, in both the left and right slots (mono).
// The block is the I2S master: it generates BCLK and LRCK from CLK.
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   SAMPLE_VALID in   one-cycle strobe, TONE holds the finished mix
//   TONE[31:0]   in   signed two's-complement mixed sample
//   SAMPLE_REQ   out  one-cycle pulse at each frame start
//   AUD_BCLK     out  I2S bit clock, CLK / (2*BCLK_HALF)
//   AUD_DACLRCK  out  I2S word select, 0 = left slot, 1 = right slot
//   AUD_DACDAT   out  I2S serial data, MSB first, one BCLK after LRCK edge
//   UNDERRUN     out  one-cycle pulse, frame start found no pending sample
//   OVERRUN      out  one-cycle pulse, a new sample replaced an unplayed one
//
// Parameters
//   BCLK_HALF    CLK cycles per BCLK half period
//   SHIFT        arithmetic right shift before saturation, 0..16
//------------------------------------------------------------------------------
module tone_i2s_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SHIFT     = 12
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SAMPLE_VALID,
  input  logic [31:0] TONE,
  output logic        SAMPLE_REQ,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        UNDERRUN,
  output logic        OVERRUN
);

  localparam int               DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_HALF - 1);

  // Scale by SHIFT with sign extension, then clamp into the 16-bit range.
  function automatic logic [15:0] sat16(input logic [31:0] word);
    logic signed [31:0] scaled;
    scaled = $signed(word) >>> SHIFT;
    if (scaled > 32'sd32767) begin
      sat16 = 16'h7FFF;
    end else if (scaled < -32'sd32768) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = scaled[15:0];
    end
  endfunction

  // Bit-clock generation and serialiser state
  logic [DIV_W-1:0] div_cnt_r;
  logic             bclk_r;
  logic [5:0]       bit_cnt_r;
  logic             lrck_r;
  logic             dat_r;
  logic             sample_req_r;

  // Sample buffering state
  logic [15:0]      pend_r;
  logic [15:0]      play_r;
  logic             pending_r;
  logic             first_frame_r;
  logic             underrun_r;
  logic             overrun_r;

  // Combinational helpers
  logic             div_tc_s;
  logic             fall_s;
  logic [5:0]       bit_nxt_s;
  logic             frame_start_s;
  logic [4:0]       slot_bit_s;
  logic [3:0]       sel_s;
  logic             ser_bit_s;
  logic [15:0]      conv_s;

  // Divider terminal count, BCLK fall detection and the next serial bit
  always_comb begin
    div_tc_s      = (div_cnt_r == DIV_TC);
    // A fall event is the terminal count while BCLK is currently high.
    fall_s        = div_tc_s & bclk_r;
    bit_nxt_s     = bit_cnt_r + 6'd1;
    frame_start_s = fall_s & (bit_nxt_s == 6'd0);
    // Position inside the 32-bit slot; slot bit 0 is the I2S delay bit.
    slot_bit_s    = bit_nxt_s[4:0];
    sel_s         = 4'(5'd16 - slot_bit_s);
    if ((slot_bit_s >= 5'd1) && (slot_bit_s <= 5'd16)) begin
      ser_bit_s = play_r[sel_s];
    end else begin
      ser_bit_s = 1'b0;
    end
    conv_s        = sat16(TONE);
  end

  // BCLK divider, bit counter, LRCK / DACDAT shifting and frame-start pulse
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt_r    <= {DIV_W{1'b0}};
      bclk_r       <= 1'b0;
      bit_cnt_r    <= 6'd63;
      lrck_r       <= 1'b0;
      dat_r        <= 1'b0;
      sample_req_r <= 1'b0;
    end else begin
      if (div_tc_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bclk_r    <= ~bclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      // LRCK and data change together with the BCLK falling edge so the
      // codec samples stable values on the following rising edge.
      if (fall_s) begin
        bit_cnt_r <= bit_nxt_s;
        lrck_r    <= bit_nxt_s[5];
        dat_r     <= ser_bit_s;
      end
      sample_req_r <= frame_start_s;
    end
  end

  // Pending/play double buffer with underrun and overrun reporting
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_r        <= 16'h0000;
      play_r        <= 16'h0000;
      pending_r     <= 1'b0;
      first_frame_r <= 1'b1;
      underrun_r    <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
      if (frame_start_s) begin
        // Repeat the previous sample when nothing new arrived in time.
        if (pending_r) begin
          play_r <= pend_r;
        end
        underrun_r    <= ~pending_r & ~first_frame_r;
        first_frame_r <= 1'b0;
        // A sample arriving on this very edge becomes the next pending one;
        // it does not count as an overrun because the old one was consumed.
        pending_r     <= SAMPLE_VALID;
      end else if (SAMPLE_VALID) begin
        pending_r <= 1'b1;
        overrun_r <= pending_r;
      end
      if (SAMPLE_VALID) begin
        pend_r <= conv_s;
      end
    end
  end

  assign SAMPLE_REQ  = sample_req_r;
  assign AUD_BCLK    = bclk_r;
  assign AUD_DACLRCK = lrck_r;
  assign AUD_DACDAT  = dat_r;
  assign UNDERRUN    = underrun_r;
  assign OVERRUN     = overrun_r;

endmodule

// File: tb/tb_tone_i2s_tx.sv
//------------------------------------------------------------------------------
// tb_tone_i2s_tx
//
// Directed bench for tone_i2s_tx with BCLK_HALF=2 (256 CLK per frame) and
// SHIFT=12. The stimulus pushes the sample expected in each frame into a
// scoreboard queue. A monitor pops one entry per frame start. Every CLK, the
// monitor checks all outputs against timing derived from the number of CLK
// edges since reset release.
//------------------------------------------------------------------------------
module tb_tone_i2s_tx;

  logic        CLK;
  logic        RESET_N;
  logic        SAMPLE_VALID;
  logic [31:0] TONE;
  logic        SAMPLE_REQ;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic        UNDERRUN;
  logic        OVERRUN;

  tone_i2s_tx #(.BCLK_HALF(2), .SHIFT(12)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .SAMPLE_VALID (SAMPLE_VALID),
    .TONE         (TONE),
    .SAMPLE_REQ   (SAMPLE_REQ),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .UNDERRUN     (UNDERRUN),
    .OVERRUN      (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] smp;
    logic        ur;
  } ent_t;

  ent_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;
  int   ovr_cyc = -1;

  // CLK rising edges since reset release
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Monitor: expected waveform from edge count k
  // (fall events at k=4(j+1), frame start when j%64==0)
  int          mk, mj, mb;
  ent_t        ment;
  logic        e_req, e_ur, e_lr, e_dat;
  logic [15:0] cur_play = 16'h0000;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      chk("rst_bclk", AUD_BCLK,    0);
      chk("rst_lrck", AUD_DACLRCK, 0);
      chk("rst_dat",  AUD_DACDAT,  0);
      chk("rst_req",  SAMPLE_REQ,  0);
      chk("rst_ur",   UNDERRUN,    0);
      chk("rst_ovr",  OVERRUN,     0);
    end else begin
      mk    = cyc;
      e_req = (mk >= 4) && (((mk - 4) % 256) == 0);
      e_ur  = 1'b0;
      if (e_req) begin
        chk("sb_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ment     = exp_q.pop_front();
          cur_play = ment.smp;
          e_ur     = ment.ur;
        end
      end
      if (mk >= 4) begin
        mj    = mk / 4 - 1;
        e_lr  = ((mj % 64) >= 32);
        mb    = mj % 32;
        e_dat = ((mb >= 1) && (mb <= 16)) ? cur_play[16 - mb] : 1'b0;
      end else begin
        e_lr  = 1'b0;
        e_dat = 1'b0;
      end
      chk("bclk", AUD_BCLK,    (mk >> 1) & 1);
      chk("lrck", AUD_DACLRCK, e_lr);
      chk("dat",  AUD_DACDAT,  e_dat);
      chk("req",  SAMPLE_REQ,  e_req);
      chk("ur",   UNDERRUN,    e_ur);
      chk("ovr",  OVERRUN,     (mk == ovr_cyc));
    end
  end

  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    chk("wait_cyc", cyc, k);
  endtask

  // SAMPLE_VALID captured on rising edge k
  task automatic send(input int k, input logic [31:0] tone);
    wait_cyc(k - 1);
    SAMPLE_VALID = 1'b1;
    TONE         = tone;
    wait_cyc(k);
    SAMPLE_VALID = 1'b0;
    TONE         = 32'h0;
  endtask

  task automatic push(input logic [15:0] smp, input logic ur);
    ent_t e;
    e.smp = smp;
    e.ur  = ur;
    exp_q.push_back(e);
  endtask

  // Frame starts at edge 4 + 256*m
  initial begin
    RESET_N      = 1'b0;
    SAMPLE_VALID = 1'b1;          // must be ignored during reset
    TONE         = 32'h0123_4000;
    push(16'h0000, 1'b0);         // first frame: silent, no underrun
    push(16'h0000, 1'b1);         // second frame: underrun, repeat 0
    repeat (3) @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    TONE         = 32'h0;
    #1 RESET_N   = 1'b1;

    // Basic sample and saturation cases, one per frame
    push(16'h1234, 1'b0); send(280,  32'h0123_4000);
    push(16'h7FFF, 1'b0); send(536,  32'h7FFF_FFFF);
    push(16'h8000, 1'b0); send(792,  32'h8000_0000);
    push(16'hFFFF, 1'b0); send(1048, 32'hFFFF_F000);
    push(16'h7FFF, 1'b0); send(1304, 32'h0800_0000);

    // Two samples in one frame: second overruns and wins
    send(1560, 32'h1000_0000);
    ovr_cyc = 1600;
    push(16'h0005, 1'b0); send(1600, 32'h0000_5000);

    // Pending A, then B exactly on the frame-start edge 2052
    push(16'h0001, 1'b0); send(1896, 32'h0000_1000);
    push(16'h0002, 1'b0); send(2052, 32'h0000_2000);
    push(16'h0002, 1'b1);         // nothing new: underrun, repeat B

    // Pending sample then reset at bit_cnt=20 while BCLK is high
    send(2604, 32'h0000_7000);
    wait_cyc(2646);
    #1 RESET_N = 1'b0;
    #1;
    chk("async_bclk", AUD_BCLK,    0);
    chk("async_lrck", AUD_DACLRCK, 0);
    chk("async_dat",  AUD_DACDAT,  0);
    chk("async_req",  SAMPLE_REQ,  0);
    chk("async_ur",   UNDERRUN,    0);
    chk("async_ovr",  OVERRUN,     0);
    chk("sb_drained_pre_rst", exp_q.size(), 0);
    ovr_cyc = -1;
    repeat (3) @(negedge CLK);
    #1 RESET_N = 1'b1;
    push(16'h0000, 1'b0);         // pending 0x0007 discarded
    push(16'h0000, 1'b1);
    wait_cyc(510);
    chk("sb_drained_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tone_i2s_tx.md
Name: tone_i2s_tx

Overview:
- Downstream output stage of the synth voice datapath.
- Takes the 32-bit signed mixed TONE word once per audio frame, scales and saturates it to 16 bits, and double-buffers it.
- Serialises the sample as mono on both channels in I2S format to the board audio codec DAC (master mode: block generates BCLK and LRCK).
- Emits a one-cycle SAMPLE_REQ at each frame start so the voice sequencer begins accumulating the next sample.

Parameters:
- BCLK_HALF, 8: CLK cycles per BCLK half-period. BCLK = CLK/(2*BCLK_HALF); fs = BCLK/64 (48.83 kHz at 50 MHz).
- SHIFT, 12: arithmetic right shift applied to TONE before 16-bit saturation; legal range 0..16.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SAMPLE_VALID  in  1  one-cycle strobe; TONE holds the completed mix for this frame.
- TONE  in  32  signed two's-complement mixed sample.
- SAMPLE_REQ  out  1  one-cycle pulse at each frame start.
- AUD_BCLK  out  1  I2S bit clock.
- AUD_DACLRCK  out  1  I2S word select; 0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  I2S serial data, MSB first.
- UNDERRUN  out  1  one-cycle pulse: frame start found no pending sample.
- OVERRUN  out  1  one-cycle pulse: SAMPLE_VALID overwrote an unconsumed pending sample.

Behaviour:
- Reset (async assert, sync release): AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, SAMPLE_REQ=0, UNDERRUN=0, OVERRUN=0. Internal state: div_cnt=0, bit_cnt=63, pending=0, pend_reg=0, play_reg=0, first_frame=1.
- Divider: div_cnt counts 0..BCLK_HALF-1 and wraps. At the terminal count AUD_BCLK toggles.
  - A 1->0 toggle is a "fall event", taking effect in the same CLK edge.
- Fall event:
  - bit_cnt increments mod 64.
  - AUD_DACLRCK = new bit_cnt[5].
  - Let b = new bit_cnt[4:0]. AUD_DACDAT = play_reg[16-b] for b in 1..16; otherwise 0. This gives the I2S one-BCLK MSB delay after the LRCK edge; the same sample is sent in both slots.
- Frame start is the fall event where new bit_cnt == 0. On that edge:
  - play_reg <= pending ? pend_reg : play_reg (repeat the last sample on underrun).
  - pending is cleared if it was consumed.
  - SAMPLE_REQ = 1 for exactly one CLK.
  - UNDERRUN = 1 for one CLK if pending==0 and first_frame==0.
  - first_frame <= 0.
  - The bit at b=0 is 0, so the play_reg update is not visible on DACDAT until b=1.
- Conversion on SAMPLE_VALID: s = TONE >>> SHIFT (sign-preserving).
  - If s > 32767, pend_reg = 16'h7FFF.
  - If s < -32768, pend_reg = 16'h8000.
  - Otherwise pend_reg = s[15:0].
  - Set pending=1 on the same edge.
- Overrun: SAMPLE_VALID while pending==1 and not a frame-start cycle -> overwrite pend_reg, OVERRUN pulses one CLK.
- Simultaneous SAMPLE_VALID and frame start:
  - play_reg takes the old pend_reg (pre-edge value).
  - pend_reg takes the new conversion; pending ends at 1.
  - No OVERRUN.
  - UNDERRUN follows the old pending value.
- Latency: a sample accepted before frame start N appears on DACDAT starting at BCLK fall b=1 of frame N. Expected system use: SAMPLE_REQ at frame N-1 -> mix -> SAMPLE_VALID -> played in frame N.
- SAMPLE_VALID is ignored while RESET_N=0. Reset mid-frame aborts the frame; the next frame begins cleanly after release.
- The first frame after reset plays 0 with no UNDERRUN.

Test Plan (BCLK_HALF=2 -> 256 CLK/frame, SHIFT=12):
- Reset release, no stimulus:
  - BCLK period is 4 CLK.
  - LRCK toggles every 128 CLK.
  - SAMPLE_REQ pulses every 256 CLK.
  - DACDAT stays 0.
  - No UNDERRUN in the first frame; UNDERRUN on the second frame start.
- TONE=32'h0123_4000 with SAMPLE_VALID after the first SAMPLE_REQ: s=0x1234, so the next frame shifts 0001_0010_0011_0100 on b=1..16 of both slots and 0 elsewhere.
- Saturation cases:
  - TONE=32'h7FFF_FFFF -> 0x7FFF.
  - TONE=32'h8000_0000 -> 0x8000.
  - TONE=32'hFFFF_F000 -> 0xFFFF.
  - TONE=32'h0800_0000 -> 0x7FFF.
- Two SAMPLE_VALIDs (0x1000_0000 then 0x0000_5000) in one frame: OVERRUN pulses once on the second; the next frame plays 0x0005.
- SAMPLE_VALID on the exact frame-start cycle with pending sample A, new sample B:
  - A plays in this frame and B in the next.
  - No OVERRUN or UNDERRUN.
- RESET_N pulsed low at bit_cnt=20:
  - All outputs go to 0 asynchronously.
  - The pending sample is discarded.
  - Timing restarts exactly as in scenario 1.
